// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit machine sequencer: widths, opcodes, states, strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_unit_pkg;

    localparam int CU_DATA_W = 8;
    localparam int CU_ADDR_W = 5;
    localparam int CU_OPC_W  = 3;

    typedef enum logic [2:0] {
        OP_STP = 3'b000,
        OP_DOD = 3'b001,
        OP_ODE = 3'b010,
        OP_POB = 3'b011,
        OP_LAD = 3'b100,
        OP_SOB = 3'b101,
        OP_SOM = 3'b110,
        OP_SOZ = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Everything the EXEC cycle needs from one opcode.
    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic add;
        logic sub;
        logic write;
        logic read;
        logic jump;   // load PC from IR address field
        logic halt;   // go to HALT after this cycle
    } strobe_t;

endpackage

// File: rtl/control_unit_decode.sv
// Opcode decoder: maps an opcode plus accumulator flags to the EXEC strobe bundle.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, only used while in EXEC.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  opcode_t opc,
    input  logic    acc_neg,
    input  logic    acc_zero,
    output strobe_t stb
);

    // One opcode -> one set of strobes; conditional jumps fold the Acc flags in here.
    always_comb begin
        stb = '0;
        unique case (opc)
            OP_STP: stb.halt = 1'b1;
            OP_DOD: begin
                stb.mem_rd = 1'b1;
                stb.write  = 1'b1;
                stb.add    = 1'b1;
            end
            OP_ODE: begin
                stb.mem_rd = 1'b1;
                stb.write  = 1'b1;
                stb.sub    = 1'b1;
            end
            OP_POB: begin
                stb.mem_rd = 1'b1;
                stb.write  = 1'b1;
            end
            OP_LAD: begin
                stb.read   = 1'b1;
                stb.mem_wr = 1'b1;
            end
            OP_SOB: stb.jump = 1'b1;
            OP_SOM: stb.jump = acc_neg;
            OP_SOZ: stb.jump = acc_zero;
            default: stb = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Sequencer for the 8-bit machine: fetch/decode/exec over Dbus, drives ALU and memory strobes.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); ALU result on Acc one cycle after EXEC.
// Backpressure: none; memory and ALU are assumed single-cycle, start only sampled in IDLE.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int DATA_W = CU_DATA_W,
    parameter int ADDR_W = CU_ADDR_W,
    parameter int OPC_W  = CU_OPC_W,
    parameter int PC_RST = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              start,
    input  logic [DATA_W-1:0] Dbus,
    input  logic [DATA_W-1:0] Acc,
    output logic [ADDR_W-1:0] Abus,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              add,
    output logic              sub,
    output logic              write,
    output logic              read,
    output logic              halted
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   ir;
    opcode_t             opc;
    logic [ADDR_W-1:0]   ir_addr;
    strobe_t             stb;

    assign opc     = opcode_t'(ir[DATA_W-1 -: OPC_W]);
    assign ir_addr = ir[ADDR_W-1:0];

    control_unit_decode u_decode (
        .opc      (opc),
        .acc_neg  (Acc[DATA_W-1]),
        .acc_zero (Acc == '0),
        .stb      (stb)
    );

    // State, PC and IR registers; a taken jump in EXEC overrides the DECODE increment.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            pc    <= ADDR_W'(PC_RST);
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH)
                ir <= Dbus;
            if (state == S_DECODE)
                pc <= pc + 1'b1;
            if (state == S_EXEC && stb.jump)
                pc <= ir_addr;
        end
    end

    // Next-state: HALT is terminal, only reset leaves it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = stb.halt ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus and strobe outputs decoded from registered state and IR only, so reset clears them at once.
    always_comb begin
        Abus   = pc;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        halted = 1'b0;
        unique case (state)
            S_FETCH: mem_rd = 1'b1;
            S_EXEC: begin
                Abus   = ir_addr;
                mem_rd = stb.mem_rd;
                mem_wr = stb.mem_wr;
                add    = stb.add;
                sub    = stb.sub;
                write  = stb.write;
                read   = stb.read;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule
